rf_wb_arbiter: RTL and testbench

- Writeback-side initiator for the 32x32 register file write port, which has no write enable; an x0 address means no write.
- Merges two producers onto that single port:
  - in-order ALU/pipeline results, which have fixed priority;
  - out-of-order-latency load returns from the cache, buffered in a small queue with valid/ready handshake.
- Exports a per-register "load pending" mask for hazard detection in decode.

---
 rtl/rf_wb_pkg.sv | 14 +
 rtl/rf_wb_lq.sv | 51 +++++
 rtl/rf_wb_arbiter.sv | 59 +++++
 tb/tb_rf_wb_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths, load-queue entry type and rd one-hot helper for the writeback arbiter
package rf_wb_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0] data;
    logic kill;
  } lq_entry_t;
  function automatic logic [NUM_REGS-1:0] onehot_rd(input logic [REG_AW-1:0] rd);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << rd;
  endfunction
endpackage

// File: rtl/rf_wb_lq.sv
// rf_wb_lq: circular load-return queue with broadcast kill and live-destination pending mask
module rf_wb_lq
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_push,
  input  logic [REG_AW-1:0]   i_push_rd,
  input  logic [XLEN-1:0]     i_push_data,
  input  logic                i_pop,
  input  logic                i_kill_vld,
  input  logic [REG_AW-1:0]   i_kill_rd,
  output lq_entry_t           o_head,
  output logic [3:0]          o_count,
  output logic [NUM_REGS-1:0] o_pending
);
  localparam int AW = $clog2(DEPTH);
  lq_entry_t mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] hd, tl;
  assign o_head = mem[hd];
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hd <= '0;
      tl <= '0;
      vld <= '0;
      o_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_kill_vld && mem[i].rd == i_kill_rd) mem[i].kill <= 1'b1;
      // a load arriving with a same-rd ALU write is older, so it lands already dead
      if (i_push) begin
        mem[tl] <= '{rd: i_push_rd, data: i_push_data, kill: i_kill_vld && i_push_rd == i_kill_rd};
        vld[tl] <= 1'b1;
        tl <= tl + 1'b1;
      end
      if (i_pop) begin
        vld[hd] <= 1'b0;
        hd <= hd + 1'b1;
      end
      o_count <= o_count + 4'(i_push) - 4'(i_pop);
    end
  end
  always_comb begin
    o_pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && !mem[i].kill) o_pending = o_pending | onehot_rd(mem[i].rd);
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges ALU results and queued load returns onto the RF write port; RF_WB_STATS_EN adds a stall counter
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int LQ_DEPTH = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_alu_valid,
  input  logic [REG_AW-1:0]   i_alu_rd,
  input  logic [XLEN-1:0]     i_alu_data,
  input  logic                i_ld_valid,
  output logic                o_ld_ready,
  input  logic [REG_AW-1:0]   i_ld_rd,
  input  logic [XLEN-1:0]     i_ld_data,
  output logic [REG_AW-1:0]   o_rd_waddr,
  output logic [XLEN-1:0]     o_rd_wdata,
  output logic [NUM_REGS-1:0] o_ld_pending,
  output logic [3:0]          o_lq_count,
  output logic [31:0]         o_stall_cnt
);
  lq_entry_t head;
  logic sel_alu, pop, push, wr_ld;
  assign sel_alu = i_alu_valid && i_alu_rd != '0;
  assign pop = !sel_alu && o_lq_count != '0;
  assign o_ld_ready = o_lq_count < 4'(LQ_DEPTH);
  assign push = i_ld_valid && o_ld_ready && i_ld_rd != '0;
  assign wr_ld = pop && !head.kill;
  rf_wb_lq #(.DEPTH(LQ_DEPTH)) u_lq (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push),
    .i_push_rd   (i_ld_rd),
    .i_push_data (i_ld_data),
    .i_pop       (pop),
    .i_kill_vld  (sel_alu),
    .i_kill_rd   (i_alu_rd),
    .o_head      (head),
    .o_count     (o_lq_count),
    .o_pending   (o_ld_pending)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_waddr <= '0;
      o_rd_wdata <= '0;
    end else begin
      o_rd_waddr <= sel_alu ? i_alu_rd : wr_ld ? head.rd : '0;
      o_rd_wdata <= sel_alu ? i_alu_data : wr_ld ? head.data : '0;
    end
  end
`ifdef RF_WB_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) o_stall_cnt <= '0;
    else if (sel_alu && o_lq_count != '0 && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + 1'b1;
  end
`else
  assign o_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_alu_valid = 1'b0;
  logic [4:0] i_alu_rd = '0;
  logic [31:0] i_alu_data = '0;
  logic i_ld_valid = 1'b0;
  logic [4:0] i_ld_rd = '0;
  logic [31:0] i_ld_data = '0;
  logic o_ld_ready;
  logic [4:0] o_rd_waddr;
  logic [31:0] o_rd_wdata, o_ld_pending, o_stall_cnt;
  logic [3:0] o_lq_count;
  int total = 0;
  int bad = 0;
  rf_wb_arbiter #(.LQ_DEPTH(2)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_alu_valid  (i_alu_valid),
    .i_alu_rd     (i_alu_rd),
    .i_alu_data   (i_alu_data),
    .i_ld_valid   (i_ld_valid),
    .o_ld_ready   (o_ld_ready),
    .i_ld_rd      (i_ld_rd),
    .i_ld_data    (i_ld_data),
    .o_rd_waddr   (o_rd_waddr),
    .o_rd_wdata   (o_rd_wdata),
    .o_ld_pending (o_ld_pending),
    .o_lq_count   (o_lq_count),
    .o_stall_cnt  (o_stall_cnt)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    i_alu_valid = av;
    i_alu_rd = ar;
    i_alu_data = ad;
    i_ld_valid = lv;
    i_ld_rd = lr;
    i_ld_data = ld;
  endtask
  task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_waddr"}, 32'(o_rd_waddr), 32'(a));
    chk({tag, "_wdata"}, o_rd_wdata, d);
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    i_rst = 1'b0;
    wr("rst", 0, 0);
    chk("rst_count", 32'(o_lq_count), 0);
    chk("rst_pend", o_ld_pending, 0);
    chk("rst_ready", 32'(o_ld_ready), 1);
    chk("rst_stall", o_stall_cnt, 0);
    // reset mid-drain
    drive(1, 1, 32'h100, 1, 3, 32'h11);
    tick();
    drive(1, 1, 32'h101, 1, 4, 32'h22);
    tick();
    chk("md_count", 32'(o_lq_count), 2);
    chk("md_pend", o_ld_pending, 32'h18);
    chk("md_ready", 32'(o_ld_ready), 0);
    wr("md_alu", 1, 32'h101);
    drive(0, 0, 0, 0, 0, 0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    wr("md_rst", 0, 0);
    chk("md_rst_count", 32'(o_lq_count), 0);
    chk("md_rst_pend", o_ld_pending, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      wr("md_nowr", 0, 0);
    end
    // priority: ALU for 3 cycles holds off the queued load
    drive(0, 0, 0, 1, 7, 32'hAAAA);
    tick();
    chk("pr_pend", o_ld_pending, 32'h80);
    chk("pr_count", 32'(o_lq_count), 1);
    drive(1, 9, 32'h5555, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      wr("pr_alu", 9, 32'h5555);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    wr("pr_ld", 7, 32'hAAAA);
    chk("pr_count0", 32'(o_lq_count), 0);
    chk("pr_pend0", o_ld_pending, 0);
`ifdef RF_WB_STATS_EN
    chk("pr_stall", o_stall_cnt, 3);
`else
    chk("pr_stall", o_stall_cnt, 0);
`endif
    // full/backpressure
    drive(1, 1, 32'h1, 1, 10, 32'hA0);
    tick();
    drive(1, 1, 32'h2, 1, 11, 32'hB0);
    tick();
    chk("bp_count", 32'(o_lq_count), 2);
    chk("bp_ready0", 32'(o_ld_ready), 0);
    drive(1, 1, 32'h3, 1, 12, 32'hC0);
    tick();
    chk("bp_hold_count", 32'(o_lq_count), 2);
    chk("bp_hold_pend", o_ld_pending, 32'h0C00);
    drive(0, 0, 0, 1, 12, 32'hC0);
    tick();
    wr("bp_pop1", 10, 32'hA0);
    chk("bp_pop1_count", 32'(o_lq_count), 1);
    chk("bp_ready1", 32'(o_ld_ready), 1);
    tick();
    wr("bp_pop2", 11, 32'hB0);
    chk("bp_pop2_count", 32'(o_lq_count), 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    wr("bp_pop3", 12, 32'hC0);
    chk("bp_count0", 32'(o_lq_count), 0);
    // WAW kill
    drive(0, 0, 0, 1, 5, 32'hDEAD);
    tick();
    chk("waw_pend", o_ld_pending, 32'h20);
    drive(1, 5, 32'hBEEF, 0, 0, 0);
    tick();
    wr("waw_alu", 5, 32'hBEEF);
    chk("waw_pend0", o_ld_pending, 0);
    chk("waw_count", 32'(o_lq_count), 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    wr("waw_pop", 0, 0);
    chk("waw_count0", 32'(o_lq_count), 0);
    // same-cycle tie
    drive(1, 6, 32'h2, 1, 6, 32'h1);
    tick();
    wr("tie_alu", 6, 32'h2);
    chk("tie_count", 32'(o_lq_count), 1);
    chk("tie_pend", o_ld_pending, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    wr("tie_pop", 0, 0);
    chk("tie_count0", 32'(o_lq_count), 0);
    // x0 handling
    drive(1, 0, 32'h77, 1, 0, 32'h99);
    tick();
    wr("x0", 0, 0);
    chk("x0_count", 32'(o_lq_count), 0);
    chk("x0_ready", 32'(o_ld_ready), 1);
    chk("x0_pend", o_ld_pending, 0);
    // ALU rd=0 lets the queue drain
    drive(0, 0, 0, 1, 8, 32'h88);
    tick();
    drive(1, 0, 32'h55, 0, 0, 0);
    tick();
    wr("x0_drain", 8, 32'h88);
    chk("x0_drain_count", 32'(o_lq_count), 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    wr("idle", 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
